uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 clk_i  in  1  system clock; all logic is rising-edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 ov_baud_rt_i  in  1  one-cycle tick at 16x the baud rate.
REQ-004 data_tx_i  in  8  head word of the show-ahead TX FIFO; valid while tx_fifo_empty_i=0.
REQ-005 tx_fifo_empty_i  in  1  TX FIFO empty flag.
REQ-006 data_width_i  in  2  STR.DWID code: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 parity_mode_i  in  2  STR.PMID code: 00=even, 01=odd, 10/11=no parity.
REQ-008 stop_bits_i  in  2  STR.SBID code: 00=1 stop bit, 01/10/11=2 stop bits.
REQ-009 tx_o  out  1  serial line; idles high.
REQ-010 tx_fifo_read_o  out  1  one-cycle pop strobe to the TX FIFO.
REQ-011 tx_done_o  out  1  one-cycle pulse when a frame's last stop bit completes.
REQ-012 tx_idle_o  out  1  high while the FSM is in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE with tx_fifo_empty_i=0, the block SHALL assert tx_fifo_read_o for exactly that cycle.
- Same cycle: latch data_tx_i, data_width_i, parity_mode_i and stop_bits_i into frame registers.
- Next state: START.
REQ-015 Configuration inputs changing mid-frame SHALL NOT affect the current frame.
REQ-016 A 4-bit tick counter SHALL be cleared on the IDLE->START transition and SHALL count ov_baud_rt_i pulses.
- Each bit period lasts exactly 16 ticks.
- On the 16th tick the counter wraps to 0 and the bit advances.
REQ-017 tx_o SHALL be driven from a register with the following values:
- IDLE: 1.
- START: 0.
- DATA: frame bit, LSB first.
- PARITY: parity bit.
- STOP: 1.
REQ-018 tx_o SHALL change on the clock edge following the state change, giving one cycle of fixed latency.
REQ-019 DATA SHALL emit N bits, with N from the latched width code.
- A 3-bit bit index counts 0..N-1.
- On index N-1 plus the 16th tick, the next state is PARITY if parity is enabled, else STOP.
REQ-020 The parity bit SHALL be the XOR of only the N transmitted data bits.
- Even mode: parity = XOR.
- Odd mode: parity = inverted XOR.
- Unused upper data bits are masked out.
REQ-021 PARITY SHALL last one bit period and then go to STOP.
REQ-022 STOP SHALL last 1 or 2 bit periods per the latched stop code, then go to IDLE.
REQ-023 tx_done_o SHALL pulse in the same cycle as the STOP->IDLE transition.
REQ-024 Back-to-back frames: if the FIFO is non-empty on the cycle after returning to IDLE, the next pop and START SHALL occur then.
- Minimum inter-frame gap: one clock cycle with tx_o=1.
REQ-025 tx_fifo_read_o SHALL never assert outside IDLE and SHALL never assert while tx_fifo_empty_i=1.
REQ-026 Ticks arriving in IDLE SHALL be ignored.

Reset
REQ-027 Under rst_i=1 the block SHALL force the following, overriding any in-progress frame:
- state=IDLE, tx_o=1, tx_fifo_read_o=0, tx_done_o=0, tx_idle_o=1.
- Tick counter, bit index and frame registers cleared.
REQ-028 A reset asserted mid-frame SHALL take effect at the next edge.
- No tx_done_o pulse.
- The popped word is discarded.
REQ-029 After reset deassertion, the first pop SHALL occur no earlier than the first cycle with rst_i=0.

Verification
REQ-030 Basic frame: 8N1, data 0x55, tick every 4 clocks -> tx_o = 0,1,0,1,0,1,0,1,0,1.
- Each bit held 64 clocks.
- One tx_fifo_read_o pulse; tx_done_o after 640 clocks.
REQ-031 Masked parity frame: 5E2 (DWID=00, PMID=00, SBID=01), data 0xFF -> data bits 11111 only, parity 1, two stop bits of 16 ticks each.
- Total frame 9 bit periods.
REQ-032 Odd parity frame: 7O1, data 0x03 -> parity bit 1, frame 10 bit periods.
REQ-033 Back-to-back frames: FIFO holds 0xA5 then 0x3C -> two pops, two tx_done_o pulses, exactly one idle cycle with tx_o=1 between frames.
REQ-034 Mid-frame config and reset: change data_width_i in DATA -> current frame keeps its latched width.
- Then assert rst_i in DATA bit 3 -> next cycle tx_o=1, tx_idle_o=1, no tx_done_o.
REQ-035 Empty FIFO: hold tx_fifo_empty_i=1 for 1000 cycles -> tx_fifo_read_o stays 0, tx_o stays 1, tx_idle_o stays 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serial transmitter fed from a show-ahead TX FIFO
module uart_transmitter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_baud_rt_i,
  input  logic [7:0] data_tx_i,
  input  logic       tx_fifo_empty_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  output logic       tx_o,
  output logic       tx_fifo_read_o,
  output logic       tx_done_o,
  output logic       tx_idle_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic [7:0] frame_data;
  logic [1:0] frame_width;
  logic [1:0] frame_pmode;
  logic [1:0] frame_stop;

  logic       bit_end;
  logic       pop;
  logic [2:0] last_idx;
  logic       parity_en;
  logic       last_stop;
  logic [7:0] data_mask;
  logic       parity_bit;
  logic       tx_bit;

  assign bit_end   = ov_baud_rt_i && (tick_cnt == 4'hF);
  assign pop       = (state == IDLE) && !tx_fifo_empty_i;
  assign last_idx  = 3'd4 + {1'b0, frame_width};
  assign parity_en = !frame_pmode[1];
  assign last_stop = (frame_stop == 2'b00) || stop_idx;

  // Parity covers only the bits actually shifted out for this width.
  always_comb begin
    data_mask = 8'hFF;
    case (frame_width)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  assign parity_bit = (^(frame_data & data_mask)) ^ frame_pmode[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!tx_fifo_empty_i) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == last_idx)) state_nxt = parity_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = frame_data[bit_idx];
      PARITY:  tx_bit = parity_bit;
      default: tx_bit = 1'b1;
    endcase
  end

  assign tx_fifo_read_o = !rst_i && pop;
  assign tx_done_o      = !rst_i && (state == STOP) && bit_end && last_stop;
  assign tx_idle_o      = (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt    <= 4'd0;
      bit_idx     <= 3'd0;
      stop_idx    <= 1'b0;
      frame_data  <= 8'd0;
      frame_width <= 2'd0;
      frame_pmode <= 2'd0;
      frame_stop  <= 2'd0;
      tx_o        <= 1'b1;
    end else begin
      // Line output trails the state by one cycle.
      tx_o <= tx_bit;

      if (state == IDLE)     tick_cnt <= 4'd0;
      else if (ov_baud_rt_i) tick_cnt <= tick_cnt + 4'd1;

      if (state != DATA)     bit_idx <= 3'd0;
      else if (bit_end)      bit_idx <= bit_idx + 3'd1;

      if (state != STOP)     stop_idx <= 1'b0;
      else if (bit_end)      stop_idx <= 1'b1;

      if (pop) begin
        frame_data  <= data_tx_i;
        frame_width <= data_width_i;
        frame_pmode <= parity_mode_i;
        frame_stop  <= stop_bits_i;
      end
    end
  end

endmodule
